alu_writeback_queue: RTL and testbench
======================================

# alu_writeback_queue

Result buffer that sits directly downstream of the ALU. It captures each ALU result (16-bit data, 4-bit flags, destination register index) with a valid/ready handshake and queues it in a small FIFO. It drains entries in order toward the register-file write port. On each drain it also commits the flags to the architectural flag register, so the ALU never stalls on a busy write port.

## Interface

Parameters:
- DEPTH, 4: FIFO entries; power of two, ≥ 2.
- DEST_W, 3: width of the destination register index.

Ports:
- Clock, input, 1: single clock; all state updates on the rising edge.
- Reset, input, 1: synchronous, active-low; sampled on the rising edge of Clock.
- InValid, input, 1: producer offers an entry this cycle.
- InReady, output, 1: queue accepts an entry; equals !Full and does not depend on OutReady.
- InData, input, 16: ALU result.
- InFlags, input, 4: ALU flags ordered {Z,C,N,O}.
- InFlagWE, input, 1: entry updates the architectural flags when drained.
- InDest, input, DEST_W: destination register index.
- OutValid, output, 1: head entry is valid.
- OutReady, input, 1: write port consumes the head this cycle.
- OutData, output, 16: head data.
- OutFlags, output, 4: head flags {Z,C,N,O}.
- OutFlagWE, output, 1: head flag-write enable.
- OutDest, output, DEST_W: head destination index.
- CommittedFlags, output, 4: architectural flags {Z,C,N,O}.
- Count, output, $clog2(DEPTH)+1: number of occupied entries.
- Full, output, 1: Count == DEPTH.
- Empty, output, 1: Count == 0.

## Operation

- Push: occurs when InValid && InReady. {InData, InFlags, InFlagWE, InDest} is written at the write pointer; the write pointer increments modulo DEPTH.
- Pop: occurs when OutValid && OutReady. The read pointer increments modulo DEPTH.
  - If the popped OutFlagWE=1, CommittedFlags <= OutFlags.
  - Otherwise CommittedFlags holds its value.
- Count update:
  - +1 on push only.
  - −1 on pop only.
  - Unchanged on simultaneous push and pop, or when neither occurs.
- Out* fields are driven combinationally from the head entry. When Empty, the Out* data fields are don't-care, but OutValid=0.
- Pointers are $clog2(DEPTH) bits and wrap naturally from DEPTH−1 to 0. Full and Empty are derived from Count, never from pointer equality.
- Full: InReady=0. A push attempt is ignored and the producer must hold its inputs. A same-cycle pop does not free a slot for that cycle's push.
- Empty: OutValid=0, and OutReady is ignored.
- Reset (Reset=0 at a rising edge) has priority over push and pop in the same cycle. It sets:
  - pointers = 0, Count = 0
  - CommittedFlags = 4'b0000
  - hence Empty=1, Full=0, InReady=1, OutValid=0.
- Reset mid-operation discards all queued entries. Storage contents are not cleared and are never observable while Empty.

## Timing

- Push-to-OutValid latency: 1 cycle (bypass build excepted, see Configuration).
- Throughput: one push and one pop per cycle sustained when 0 < Count < DEPTH.
- A pop's flag commit is visible on CommittedFlags the cycle after the handshake.
- No combinational path from OutReady to InReady. The only In→Out combinational path exists in the bypass build.
- Reset-value summary: InReady=1, OutValid=0, Count=0, Full=0, Empty=1, CommittedFlags=0. OutData, OutFlags, OutFlagWE and OutDest are 0 in the bypass build with InValid=0; otherwise don't-care.

## Configuration

- Macro: WB_BYPASS_EN.
- Defined: when Empty && InValid && OutReady, the input passes straight through in the same cycle:
  - OutValid=1 and Out* = In*, combinationally;
  - the transfer completes with zero latency;
  - the FIFO is not written and Count stays 0;
  - the flag commit still occurs at that edge when InFlagWE=1.
  - When Empty and InValid=0, OutValid=0 and Out* are driven as 0.
- Undefined: no bypass; every entry passes through storage with 1-cycle minimum latency.

## Test plan

- Reset then idle: hold Reset=0 for 2 cycles, then release → Count=0, Empty=1, InReady=1, OutValid=0, CommittedFlags=0000.
- Single entry: push 16'h00FF, flags 4'b0010, FlagWE=1, dest 3 with OutReady=0 → next cycle OutValid=1, OutData=16'h00FF, OutDest=3. Raise OutReady for 1 cycle → Empty=1, CommittedFlags=0010.
- Fill and backpressure: OutReady=0, push 16'h0001, 16'h0002, 16'h0003, 16'h0004, then offer 16'h0005 → Full=1, InReady=0, 16'h0005 not accepted. Drain → outputs 1, 2, 3, 4 in order.
- Wrap-around under streaming: push and pop every cycle for 10 cycles, values 16'h0010 to 16'h0019 → Count stays constant, output order preserved across pointer wrap.
- FlagWE masking: pop entry A (flags 1000, FlagWE=1), then entry B (flags 0101, FlagWE=0) → CommittedFlags=1000 after both pops.
- Reset mid-operation, with Count=3 and a push and pop asserted in the same cycle as Reset=0 → next cycle Count=0, OutValid=0, CommittedFlags=0000. With WB_BYPASS_EN: Empty, InValid=1, OutReady=1, InData=16'hABCD → OutData=16'hABCD in the same cycle, Count remains 0.

Source files
------------

// File: rtl/alu_writeback_queue.sv
// In-order writeback FIFO between the ALU and the register-file write port; commits flags on drain.
// Optional same-cycle empty-queue pass-through is enabled by defining WB_BYPASS_EN.
module alu_writeback_queue #(
  parameter int DEPTH  = 4,
  parameter int DEST_W = 3
) (
  input  logic                     Clock,
  input  logic                     Reset,
  input  logic                     InValid,
  output logic                     InReady,
  input  logic [15:0]              InData,
  input  logic [3:0]               InFlags,
  input  logic                     InFlagWE,
  input  logic [DEST_W-1:0]        InDest,
  output logic                     OutValid,
  input  logic                     OutReady,
  output logic [15:0]              OutData,
  output logic [3:0]               OutFlags,
  output logic                     OutFlagWE,
  output logic [DEST_W-1:0]        OutDest,
  output logic [3:0]               CommittedFlags,
  output logic [$clog2(DEPTH):0]   Count,
  output logic                     Full,
  output logic                     Empty
);

  localparam int DATA_W = 16;
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = PTR_W + 1;

  logic [DATA_W-1:0] data_mem  [DEPTH];
  logic [3:0]        flags_mem [DEPTH];
  logic              fwe_mem   [DEPTH];
  logic [DEST_W-1:0] dest_mem  [DEPTH];

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count_q;
  logic [3:0]       committed_q;

  logic bypass;
  logic push_store;
  logic pop_store;
  logic commit;

  assign Full           = (count_q == CNT_W'(DEPTH));
  assign Empty          = (count_q == '0);
  assign Count          = count_q;
  assign CommittedFlags = committed_q;
  assign InReady        = !Full;

`ifdef WB_BYPASS_EN
  assign bypass = Empty && InValid && OutReady;
`else
  assign bypass = 1'b0;
`endif

  // A bypassed transfer never touches storage or the occupancy count.
  assign push_store = InValid && InReady && !bypass;
  assign pop_store  = !Empty && OutReady;
  assign commit     = OutValid && OutReady && OutFlagWE;

  always_comb begin
    OutValid  = !Empty;
    OutData   = data_mem[rd_ptr];
    OutFlags  = flags_mem[rd_ptr];
    OutFlagWE = fwe_mem[rd_ptr];
    OutDest   = dest_mem[rd_ptr];
`ifdef WB_BYPASS_EN
    if (Empty) begin
      OutValid = bypass;
      if (InValid) begin
        OutData   = InData;
        OutFlags  = InFlags;
        OutFlagWE = InFlagWE;
        OutDest   = InDest;
      end else begin
        OutData   = '0;
        OutFlags  = '0;
        OutFlagWE = 1'b0;
        OutDest   = '0;
      end
    end
`endif
  end

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count_q     <= '0;
      committed_q <= 4'b0000;
    end else begin
      if (push_store) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_store)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push_store, pop_store})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
      if (commit) committed_q <= OutFlags;
    end
  end

  // Storage is left uncleared by reset; it is unobservable while Empty.
  always_ff @(posedge Clock) begin
    if (push_store) begin
      data_mem[wr_ptr]  <= InData;
      flags_mem[wr_ptr] <= InFlags;
      fwe_mem[wr_ptr]   <= InFlagWE;
      dest_mem[wr_ptr]  <= InDest;
    end
  end

endmodule

// File: tb/tb_alu_writeback_queue.sv
// Self-checking bench for alu_writeback_queue: directed scenarios plus randomized traffic
// compared every cycle against a queue-based reference model (bypass modelled under WB_BYPASS_EN).
module tb_alu_writeback_queue;

  localparam int DEPTH  = 4;
  localparam int DEST_W = 3;

  typedef struct packed {
    logic [15:0]       d;
    logic [3:0]        f;
    logic              we;
    logic [DEST_W-1:0] dest;
  } ent_t;

  logic              Clock = 1'b0;
  logic              Reset = 1'b0;
  logic              InValid = 1'b0;
  logic              InReady;
  logic [15:0]       InData = '0;
  logic [3:0]        InFlags = '0;
  logic              InFlagWE = 1'b0;
  logic [DEST_W-1:0] InDest = '0;
  logic              OutValid;
  logic              OutReady = 1'b0;
  logic [15:0]       OutData;
  logic [3:0]        OutFlags;
  logic              OutFlagWE;
  logic [DEST_W-1:0] OutDest;
  logic [3:0]        CommittedFlags;
  logic [$clog2(DEPTH):0] Count;
  logic              Full;
  logic              Empty;

  int passed = 0;
  int total  = 0;
  bit armed  = 1'b0;

  alu_writeback_queue #(.DEPTH(DEPTH), .DEST_W(DEST_W)) dut (
    .Clock(Clock), .Reset(Reset),
    .InValid(InValid), .InReady(InReady), .InData(InData), .InFlags(InFlags),
    .InFlagWE(InFlagWE), .InDest(InDest),
    .OutValid(OutValid), .OutReady(OutReady), .OutData(OutData), .OutFlags(OutFlags),
    .OutFlagWE(OutFlagWE), .OutDest(OutDest),
    .CommittedFlags(CommittedFlags), .Count(Count), .Full(Full), .Empty(Empty)
  );

  always #5 Clock = ~Clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  // Reference model: a queue of entries plus the architectural flag register.
  ent_t      mq[$];
  logic [3:0] mcf = 4'b0000;

  always @(negedge Clock) begin
    if (armed) begin
      automatic bit   exp_ov;
      automatic bit   byp = 1'b0;
      automatic bit   do_push;
      automatic ent_t head;
      automatic ent_t inent;
      inent = '{d: InData, f: InFlags, we: InFlagWE, dest: InDest};
`ifdef WB_BYPASS_EN
      byp = (mq.size() == 0) && InValid && OutReady;
`endif
      exp_ov = (mq.size() > 0) || byp;
      head   = (mq.size() > 0) ? mq[0] : inent;
      chk("count", 32'(Count), 32'(mq.size()));
      chk("full", 32'(Full), 32'(mq.size() == DEPTH));
      chk("empty", 32'(Empty), 32'(mq.size() == 0));
      chk("in_ready", 32'(InReady), 32'(mq.size() < DEPTH));
      chk("out_valid", 32'(OutValid), 32'(exp_ov));
      chk("committed", 32'(CommittedFlags), 32'(mcf));
      if (exp_ov) begin
        chk("out_data", 32'(OutData), 32'(head.d));
        chk("out_flags", 32'(OutFlags), 32'(head.f));
        chk("out_we", 32'(OutFlagWE), 32'(head.we));
        chk("out_dest", 32'(OutDest), 32'(head.dest));
      end
`ifdef WB_BYPASS_EN
      else if (!InValid) begin
        chk("idle_out_zero", {OutData, OutFlags, OutFlagWE, OutDest}, 32'd0);
      end
`endif
      // Advance the model to the state after the coming rising edge.
      do_push = InValid && (mq.size() < DEPTH);
      if (!Reset) begin
        mq.delete();
        mcf = 4'b0000;
      end else if (byp) begin
        if (InFlagWE) mcf = InFlags;
      end else begin
        if (exp_ov && OutReady) begin
          head = mq.pop_front();
          if (head.we) mcf = head.f;
        end
        if (do_push) mq.push_back(inent);
      end
    end
  end

  initial begin
    Reset = 1'b0;
    tick();
    armed = 1'b1;
    tick();
    Reset = 1'b1;
    tick();
    chk("rst_count", 32'(Count), 32'd0);
    chk("rst_empty", 32'(Empty), 32'd1);
    chk("rst_in_ready", 32'(InReady), 32'd1);
    chk("rst_out_valid", 32'(OutValid), 32'd0);
    chk("rst_committed", 32'(CommittedFlags), 32'd0);

    // Single entry with flag commit.
    InValid = 1'b1; InData = 16'h00FF; InFlags = 4'b0010; InFlagWE = 1'b1; InDest = 3'd3;
    OutReady = 1'b0;
    tick();
    InValid = 1'b0;
    chk("single_valid", 32'(OutValid), 32'd1);
    chk("single_data", 32'(OutData), 32'h00FF);
    chk("single_dest", 32'(OutDest), 32'd3);
    OutReady = 1'b1;
    tick();
    OutReady = 1'b0;
    chk("single_empty", 32'(Empty), 32'd1);
    chk("single_cf", 32'(CommittedFlags), 32'b0010);

    // Fill to capacity, then offer one more while full.
    InFlagWE = 1'b0; InFlags = 4'b0000; InDest = 3'd1;
    for (int k = 1; k <= 4; k++) begin
      InValid = 1'b1; InData = 16'(k);
      tick();
    end
    InData = 16'h0005;
    chk("fill_full", 32'(Full), 32'd1);
    chk("fill_in_ready", 32'(InReady), 32'd0);
    tick();
    InValid = 1'b0;
    chk("fill_reject", 32'(Count), 32'd4);
    OutReady = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      chk("drain_order", 32'(OutData), 32'(k));
      tick();
    end
    OutReady = 1'b0;
    chk("drain_empty", 32'(Empty), 32'd1);

    // Streaming across pointer wrap with two entries pre-loaded.
    InValid = 1'b1; InData = 16'h000E;
    tick();
    InData = 16'h000F;
    tick();
    OutReady = 1'b1;
    for (int i = 0; i < 10; i++) begin
      InData = 16'h0010 + 16'(i);
      chk("stream_count", 32'(Count), 32'd2);
      chk("stream_order", 32'(OutData), 32'(16'h000E + 16'(i)));
      tick();
    end
    InValid = 1'b0;
    tick();
    tick();
    OutReady = 1'b0;
    chk("stream_empty", 32'(Empty), 32'd1);

    // Flag-write masking.
    InValid = 1'b1; InData = 16'h000A; InFlags = 4'b1000; InFlagWE = 1'b1;
    tick();
    InData = 16'h000B; InFlags = 4'b0101; InFlagWE = 1'b0;
    tick();
    InValid = 1'b0;
    OutReady = 1'b1;
    tick();
    tick();
    OutReady = 1'b0;
    chk("mask_cf", 32'(CommittedFlags), 32'b1000);

    // Reset with push and pop in the same cycle.
    InValid = 1'b1; InFlagWE = 1'b1; InFlags = 4'b0110;
    for (int k = 0; k < 3; k++) begin
      InData = 16'h0100 + 16'(k);
      tick();
    end
    chk("pre_rst_count", 32'(Count), 32'd3);
    Reset = 1'b0; OutReady = 1'b1;
    tick();
    Reset = 1'b1; InValid = 1'b0; OutReady = 1'b0;
    chk("midrst_count", 32'(Count), 32'd0);
    chk("midrst_out_valid", 32'(OutValid), 32'd0);
    chk("midrst_cf", 32'(CommittedFlags), 32'd0);

`ifdef WB_BYPASS_EN
    InValid = 1'b1; OutReady = 1'b1; InData = 16'hABCD; InFlags = 4'b0001; InFlagWE = 1'b1;
    #1;
    chk("bypass_valid", 32'(OutValid), 32'd1);
    chk("bypass_data", 32'(OutData), 32'hABCD);
    tick();
    InValid = 1'b0; OutReady = 1'b0;
    chk("bypass_count", 32'(Count), 32'd0);
    chk("bypass_cf", 32'(CommittedFlags), 32'b0001);
`endif

    // Randomized traffic with occasional resets.
    for (int c = 0; c < 3000; c++) begin
      Reset    = ($urandom_range(0, 99) != 0);
      InValid  = ($urandom_range(0, 3) != 0);
      OutReady = ($urandom_range(0, 2) != 0);
      InData   = 16'($urandom);
      InFlags  = 4'($urandom);
      InFlagWE = 1'($urandom);
      InDest   = DEST_W'($urandom);
      tick();
    end
    Reset = 1'b1; InValid = 1'b0; OutReady = 1'b0;
    tick();
    tick();
    @(posedge Clock);
    armed = 1'b0;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
